// File: rtl/even_parity_frame_rx.sv
// even_parity_frame_rx: UART-style receiver feeding an even-parity checker.
// Frame: start(0), DATA_W data bits LSB first, parity bit, stop(1).
// Ports: clk, rst_n (async, active low), rx_in (async serial line),
//   data_out/par_out/frame_err/out_valid with out_ready handshake,
//   overrun (1-clk pulse when a finished frame is dropped), busy.
module even_parity_frame_rx #(
    parameter int DATA_W   = 3,
    parameter int BAUD_DIV = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_in,
    output logic [DATA_W-1:0] data_out,
    output logic              par_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              frame_err,
    output logic              overrun,
    output logic              busy
);

    localparam int CNT_W = $clog2(BAUD_DIV);
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_BREAK  = 3'd5;

    logic              sync1_q, sync2_q;
    logic              rx_s;
    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              par_sh_q, par_sh_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              par_q, par_d;
    logic              valid_q, valid_d;
    logic              ferr_q, ferr_d;
    logic              ovr_q, ovr_d;

    assign rx_s = sync2_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        par_sh_d = par_sh_q;
        data_d   = data_q;
        par_d    = par_q;
        ferr_d   = ferr_q;
        // A transfer this edge clears valid unless a publish below re-arms it.
        valid_d  = valid_q & ~out_ready;
        ovr_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rx_s) state_d = S_START;
            end
            S_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rx_s ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s;
                    if (idx_q == IDX_LAST) state_d = S_PARITY;
                    else                   idx_d   = idx_q + IDX_ONE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_PARITY: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d    = '0;
                    par_sh_d = rx_s;
                    state_d  = S_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = rx_s ? S_IDLE : S_BREAK;
                    // Slot is free if empty or being emptied this same edge.
                    if (!valid_q || out_ready) begin
                        data_d  = shift_q;
                        par_d   = par_sh_q;
                        ferr_d  = ~rx_s;
                        valid_d = 1'b1;
                    end else begin
                        ovr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_BREAK: begin
                // A held-low line must go high before a new start is seen.
                if (rx_s) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            par_sh_q <= 1'b0;
            data_q   <= '0;
            par_q    <= 1'b0;
            valid_q  <= 1'b0;
            ferr_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            sync1_q  <= rx_in;
            sync2_q  <= sync1_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            par_sh_q <= par_sh_d;
            data_q   <= data_d;
            par_q    <= par_d;
            valid_q  <= valid_d;
            ferr_q   <= ferr_d;
            ovr_q    <= ovr_d;
        end
    end

    assign data_out  = data_q;
    assign par_out   = par_q;
    assign out_valid = valid_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_even_parity_frame_rx.sv
// Bench for even_parity_frame_rx: directed frames plus random traffic,
// checked every cycle against a timing-arithmetic model of the receiver.
module tb_even_parity_frame_rx;

    localparam int DW = 3;
    localparam int B  = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx_in = 1'b1;
    logic          out_ready = 1'b0;
    logic [DW-1:0] data_out;
    logic          par_out, out_valid, frame_err, overrun, busy;

    int tests = 0;
    int fails = 0;
    int ovr_cnt = 0;
    int xfer_cnt = 0;

    even_parity_frame_rx #(.DATA_W(DW), .BAUD_DIV(B)) dut (
        .clk(clk), .rst_n(rst_n), .rx_in(rx_in),
        .data_out(data_out), .par_out(par_out),
        .out_valid(out_valid), .out_ready(out_ready),
        .frame_err(frame_err), .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [15:0] act,
                                logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endfunction

    // Model: line seen through two sync stages; a frame is timed from the
    // edge where the low start was first seen, sampling every B clocks
    // after a half-bit start check.
    logic          s1 = 1'b1, s2 = 1'b1;
    int            phase = 0;
    int            t0 = 0;
    int            cyc = 0;
    logic [DW-1:0] m_sh = '0;
    logic          m_psh = 1'b0;
    logic [DW-1:0] m_data = '0;
    logic          m_par = 1'b0, m_valid = 1'b0;
    logic          m_ferr = 1'b0, m_ovr = 1'b0;

    task automatic model_step();
        logic rs;
        logic pub;
        int   el, k;
        cyc++;
        if (!rst_n) begin
            s1 = 1'b1; s2 = 1'b1; phase = 0;
            m_sh = '0; m_psh = 1'b0; m_data = '0; m_par = 1'b0;
            m_valid = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
            return;
        end
        rs = s2;
        s2 = s1;
        s1 = rx_in;
        pub = 1'b0;
        m_ovr = 1'b0;
        if (phase == 0) begin
            if (!rs) begin phase = 1; t0 = cyc; end
        end else if (phase == 1) begin
            el = cyc - t0;
            if (el == B / 2) begin
                if (rs) phase = 0;
            end else if (el > B / 2 && (el - B / 2) % B == 0) begin
                k = (el - B / 2) / B;
                if (k <= DW) m_sh[k-1] = rs;
                else if (k == DW + 1) m_psh = rs;
                else begin
                    pub = 1'b1;
                    phase = rs ? 0 : 2;
                end
            end
        end else begin
            if (rs) phase = 0;
        end
        if (pub) begin
            if (!m_valid || out_ready) begin
                m_data = m_sh; m_par = m_psh;
                m_ferr = ~rs; m_valid = 1'b1;
            end else begin
                m_ovr = 1'b1;
            end
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
    endtask

    // Per-cycle compare; also tallies overrun pulses and transfers.
    initial begin
        logic prev_valid;
        prev_valid = 1'b0;
        forever begin
            @(posedge clk);
            model_step();
            #1;
            chk("out_valid", 16'(out_valid), 16'(m_valid));
            chk("data_out", 16'(data_out), 16'(m_data));
            chk("par_out", 16'(par_out), 16'(m_par));
            chk("frame_err", 16'(frame_err), 16'(m_ferr));
            chk("overrun", 16'(overrun), 16'(m_ovr));
            chk("busy", 16'(busy), 16'(phase != 0));
            if (prev_valid && out_ready) xfer_cnt++;
            prev_valid = out_valid;
            if (overrun === 1'b1) ovr_cnt++;
        end
    end

    task automatic drive_bit(input logic v, input int n);
        repeat (n) begin
            @(negedge clk);
            rx_in = v;
        end
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input logic p,
                              input logic stp);
        drive_bit(1'b0, B);
        for (int i = 0; i < DW; i++) drive_bit(d[i], B);
        drive_bit(p, B);
        drive_bit(stp, B);
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (out_valid !== 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (out_valid !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL %s: out_valid timeout got 0 expected 1", name);
        end
    endtask

    task automatic pulse_ready();
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ob, xb;
        logic [DW-1:0] d;
        logic p, stp;
        logic done;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_valid", 16'(out_valid), 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive_bit(1'b1, 4);

        // 1: good frame 1,0,1 parity 0
        send_frame(3'b101, 1'b0, 1'b1);
        drive_bit(1'b1, 2);
        wait_valid("t1");
        chk("t1_data", 16'(data_out), 16'h5);
        chk("t1_par", 16'(par_out), 16'd0);
        chk("t1_ferr", 16'(frame_err), 16'd0);
        chk("t1_checker", 16'(^{data_out, par_out}), 16'd0);
        pulse_ready();
        chk("t1_drop", 16'(out_valid), 16'd0);

        // 2: 3-clk low glitch while idle
        drive_bit(1'b0, 3);
        drive_bit(1'b1, 2 * B);
        chk("t2_valid", 16'(out_valid), 16'd0);
        chk("t2_busy", 16'(busy), 16'd0);

        // 3: framing error, line held low afterwards
        send_frame(3'b011, 1'b1, 1'b0);
        drive_bit(1'b0, 3 * B);
        wait_valid("t3");
        chk("t3_data", 16'(data_out), 16'h3);
        chk("t3_par", 16'(par_out), 16'd1);
        chk("t3_ferr", 16'(frame_err), 16'd1);
        chk("t3_break", 16'(busy), 16'd1);
        drive_bit(1'b1, 4);
        chk("t3_idle", 16'(busy), 16'd0);
        pulse_ready();

        // 4: back-to-back with ready low -> overrun
        ob = ovr_cnt;
        send_frame(3'b100, 1'b1, 1'b1);
        send_frame(3'b011, 1'b0, 1'b1);
        drive_bit(1'b1, 4);
        chk("t4_ovr", 16'(ovr_cnt - ob), 16'd1);
        chk("t4_data", 16'(data_out), 16'h4);
        chk("t4_valid", 16'(out_valid), 16'd1);
        pulse_ready();
        chk("t4_drop", 16'(out_valid), 16'd0);

        // 5: back-to-back with ready high
        ob = ovr_cnt;
        xb = xfer_cnt;
        @(negedge clk);
        out_ready = 1'b1;
        send_frame(3'b101, 1'b0, 1'b1);
        send_frame(3'b111, 1'b1, 1'b1);
        drive_bit(1'b1, 2 * B);
        chk("t5_xfers", 16'(xfer_cnt - xb), 16'd2);
        chk("t5_ovr", 16'(ovr_cnt - ob), 16'd0);
        chk("t5_data", 16'(data_out), 16'h7);
        out_ready = 1'b0;

        // 6: reset during the second data bit
        drive_bit(1'b0, B);
        drive_bit(1'b1, B);
        drive_bit(1'b0, 3);
        @(negedge clk);
        rst_n = 1'b0;
        rx_in = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_rst_data", 16'(data_out), 16'd0);
        chk("t6_rst_valid", 16'(out_valid), 16'd0);
        chk("t6_rst_busy", 16'(busy), 16'd0);
        chk("t6_rst_par", 16'(par_out), 16'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        drive_bit(1'b1, 2 * B);
        chk("t6_nopartial", 16'(out_valid), 16'd0);
        send_frame(3'b110, 1'b0, 1'b1);
        drive_bit(1'b1, 2);
        wait_valid("t6");
        chk("t6_data", 16'(data_out), 16'h6);
        chk("t6_par", 16'(par_out), 16'd0);
        pulse_ready();

        // Random traffic with random ready and occasional glitches.
        done = 1'b0;
        fork
            begin
                for (int f = 0; f < 40; f++) begin
                    if ($urandom_range(0, 5) == 0) begin
                        drive_bit(1'b0, $urandom_range(1, 3));
                        drive_bit(1'b1, B);
                    end
                    d = DW'($urandom_range(0, 7));
                    p = ^d ^ ($urandom_range(0, 3) == 0);
                    stp = ($urandom_range(0, 5) != 0);
                    send_frame(d, p, stp);
                    if (!stp) drive_bit(1'b0, $urandom_range(0, 20));
                    drive_bit(1'b1, $urandom_range(1, 4));
                end
                drive_bit(1'b1, 2 * B);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(negedge clk);
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        drive_bit(1'b1, 4);
        chk("end_valid", 16'(out_valid), 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
